cache_fill_arbiter: RTL and testbench

CACHE_FILL_ARBITER -- requirements
Module: cache_fill_arbiter

---
 rtl/cache_fill_arbiter.sv | 135 +++++++++++++
 tb/tb_cache_fill_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_arbiter.sv
// Shares one main-memory read port between I-cache and D-cache misses:
// streams an 8-word block into the granted cache, then writes its tag.
module cache_fill_arbiter #(
  parameter int MEM_LATENCY = 4,
  parameter int BLOCK_WORDS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_miss,
  input  logic [15:0] i_addr,
  input  logic        d_miss,
  input  logic [15:0] d_addr,
  input  logic [15:0] mem_data_out,
  input  logic        mem_data_valid,
  output logic        mem_en,
  output logic [15:0] mem_addr,
  output logic [1:0]  i_cacheop,
  output logic [1:0]  d_cacheop,
  output logic [15:0] fill_addr,
  output logic [15:0] fill_data,
  output logic        i_stall,
  output logic        d_stall,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    TAG
  } state_t;

  localparam logic [2:0] LAST    = 3'(BLOCK_WORDS - 1);
  localparam logic [1:0] OP_READ = 2'b00;
  localparam logic [1:0] OP_FILL = 2'b01;
  localparam logic [1:0] OP_TAG  = 2'b10;

  state_t      r_state;
  logic        r_grant_d;
  logic        r_last_d;
  logic [11:0] r_base;
  logic [2:0]  r_issue;
  logic [2:0]  r_recv;

  logic        w_fill;
  logic        w_tag;
  logic        w_done;
  logic        w_pick_d;
  logic [1:0]  w_op;
  logic        w_unused;

  if (MEM_LATENCY < 1) begin : g_lat_chk
    $error("MEM_LATENCY must be at least 1");
  end

  // Word offsets within a block come from the counters, not the miss address.
  assign w_unused = ^{i_addr[3:0], d_addr[3:0]};

  assign w_fill = mem_data_valid &&
                  (r_state == FETCH || r_state == DRAIN);
  assign w_tag  = r_state == TAG;
  assign w_done = w_fill && r_recv == LAST;

  // On a tie the requester not served last wins.
  assign w_pick_d = d_miss && (!i_miss || !r_last_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_grant_d <= 1'b0;
      r_last_d  <= 1'b0;
      r_base    <= '0;
      r_issue   <= '0;
      r_recv    <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (i_miss || d_miss) begin
            r_grant_d <= w_pick_d;
            r_base    <= w_pick_d ? d_addr[15:4]
                                  : i_addr[15:4];
            r_issue   <= '0;
            r_recv    <= '0;
            r_state   <= FETCH;
          end
        end
        FETCH: begin
          r_issue <= r_issue + 3'd1;
          if (w_fill) r_recv <= r_recv + 3'd1;
          if (w_done) r_state <= TAG;
          else if (r_issue == LAST) r_state <= DRAIN;
        end
        DRAIN: begin
          if (w_fill) r_recv <= r_recv + 3'd1;
          if (w_done) r_state <= TAG;
        end
        TAG: begin
          r_last_d <= r_grant_d;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    w_op = OP_READ;
    unique case (1'b1)
      w_fill:  w_op = OP_FILL;
      w_tag:   w_op = OP_TAG;
      default: w_op = OP_READ;
    endcase
  end

  always_comb begin
    fill_addr = '0;
    unique case (1'b1)
      w_fill:  fill_addr = {r_base, r_recv, 1'b0};
      w_tag:   fill_addr = {r_base, 4'h0};
      default: fill_addr = '0;
    endcase
  end

  assign mem_en    = r_state == FETCH;
  assign mem_addr  = mem_en ? {r_base, r_issue, 1'b0} : 16'h0000;
  assign fill_data = w_fill ? mem_data_out : 16'h0000;

  assign i_cacheop = r_grant_d ? OP_READ : w_op;
  assign d_cacheop = r_grant_d ? w_op : OP_READ;

  assign busy    = r_state != IDLE;
  assign i_stall = i_miss || (busy && !r_grant_d);
  assign d_stall = d_miss || (busy && r_grant_d);

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Directed bench for cache_fill_arbiter with a fixed-latency memory model
// that returns addr ^ 0xA5A5.
module tb_cache_fill_arbiter;

  logic        clk;
  logic        rst_n;
  logic        i_miss;
  logic [15:0] i_addr;
  logic        d_miss;
  logic [15:0] d_addr;
  logic [15:0] mem_data_out;
  logic        mem_data_valid;
  logic        mem_en;
  logic [15:0] mem_addr;
  logic [1:0]  i_cacheop;
  logic [1:0]  d_cacheop;
  logic [15:0] fill_addr;
  logic [15:0] fill_data;
  logic        i_stall;
  logic        d_stall;
  logic        busy;

  int          n_tests;
  int          n_fail;
  int          lat;
  logic        stray;

  logic        pv [0:7];
  logic [15:0] pa [0:7];

  cache_fill_arbiter #(
    .MEM_LATENCY(4),
    .BLOCK_WORDS(8)
  ) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_miss        (i_miss),
    .i_addr        (i_addr),
    .d_miss        (d_miss),
    .d_addr        (d_addr),
    .mem_data_out  (mem_data_out),
    .mem_data_valid(mem_data_valid),
    .mem_en        (mem_en),
    .mem_addr      (mem_addr),
    .i_cacheop     (i_cacheop),
    .d_cacheop     (d_cacheop),
    .fill_addr     (fill_addr),
    .fill_data     (fill_data),
    .i_stall       (i_stall),
    .d_stall       (d_stall),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 8; k++) begin
        pv[k] <= 1'b0;
        pa[k] <= 16'h0;
      end
    end else begin
      pv[0] <= mem_en;
      pa[0] <= mem_addr;
      for (int k = 1; k < 8; k++) begin
        pv[k] <= pv[k-1];
        pa[k] <= pa[k-1];
      end
    end
  end

  always_comb begin
    mem_data_valid = stray | pv[lat-1];
    mem_data_out   = stray ? 16'h5A5A : (pa[lat-1] ^ 16'hA5A5);
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic reset_check();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_fill_addr", 32'(fill_addr), 32'd0);
    check("rst_fill_data", 32'(fill_data), 32'd0);
    check("rst_ops", 32'({i_cacheop, d_cacheop}), 32'd0);
    check("rst_i_stall", 32'(i_stall), 32'(i_miss));
    check("rst_d_stall", 32'(d_stall), 32'(d_miss));
  endtask

  // Entered at a negedge in IDLE with the miss already raised; the next
  // posedge is the grant. Drops the granted miss at TAG (cache now hits).
  task automatic fill_check(input logic gd,
                            input logic [15:0] addr,
                            input int drop_at);
    logic [15:0] base;
    logic [15:0] a;
    logic [1:0]  op;
    int          tagc;
    base = {addr[15:4], 4'h0};
    tagc = lat + 9;
    for (int c = 1; c <= tagc + 1; c++) begin
      @(negedge clk);
      if (c <= 8) begin
        a = base + 16'(2 * (c - 1));
        check("mem_en", 32'(mem_en), 32'd1);
        check("mem_addr", 32'(mem_addr), 32'(a));
      end else begin
        check("mem_en_off", 32'(mem_en), 32'd0);
      end
      op = 2'b00;
      a  = 16'h0;
      if (c > lat && c <= lat + 8) begin
        op = 2'b01;
        a  = base + 16'(2 * (c - lat - 1));
        check("fill_data", 32'(fill_data), 32'(a ^ 16'hA5A5));
      end else if (c == tagc) begin
        op = 2'b10;
        a  = base;
      end
      check("cacheop", 32'({i_cacheop, d_cacheop}),
            gd ? 32'({2'b00, op}) : 32'({op, 2'b00}));
      if (op != 2'b00)
        check("fill_addr", 32'(fill_addr), 32'(a));
      if (c <= tagc) begin
        check("busy", 32'(busy), 32'd1);
        check("stall", gd ? 32'(d_stall) : 32'(i_stall), 32'd1);
      end else begin
        check("busy_end", 32'(busy), 32'd0);
        check("stall_rel", gd ? 32'(d_stall) : 32'(i_stall), 32'd0);
      end
      check("other_stall", gd ? 32'(i_stall) : 32'(d_stall),
            gd ? 32'(i_miss) : 32'(d_miss));
      if (c == drop_at || c == tagc) begin
        if (gd) d_miss = 1'b0;
        else    i_miss = 1'b0;
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    clk     = 1'b0;
    rst_n   = 1'b0;
    i_miss  = 1'b0;
    d_miss  = 1'b0;
    i_addr  = 16'h0;
    d_addr  = 16'h0;
    stray   = 1'b0;
    lat     = 4;

    repeat (2) @(negedge clk);
    reset_check();
    d_miss = 1'b1;
    d_addr = 16'h1236;
    #1 reset_check();

    // D-only miss, granted on the first edge after reset release
    rst_n = 1'b1;
    fill_check(1'b1, 16'h1236, 0);

    // tie right after reset: D first, then I
    @(negedge clk);
    rst_n  = 1'b0;
    i_addr = 16'h4444;
    d_addr = 16'h8888;
    i_miss = 1'b1;
    d_miss = 1'b1;
    #1 reset_check();
    @(negedge clk);
    rst_n = 1'b1;
    fill_check(1'b1, 16'h8888, 0);
    fill_check(1'b0, 16'h4444, 0);

    // back-to-back ties alternate
    i_addr = 16'h0100;
    d_addr = 16'h0230;
    i_miss = 1'b1;
    d_miss = 1'b1;
    fill_check(1'b1, 16'h0230, 0);
    fill_check(1'b0, 16'h0100, 0);

    // top of memory, miss dropped mid-fill
    i_addr = 16'hFFFE;
    i_miss = 1'b1;
    fill_check(1'b0, 16'hFFFE, 3);

    // stray valid in IDLE
    stray = 1'b1;
    #1;
    check("stray_ops", 32'({i_cacheop, d_cacheop}), 32'd0);
    check("stray_busy", 32'(busy), 32'd0);
    @(negedge clk);
    stray  = 1'b0;
    d_addr = 16'h0046;
    d_miss = 1'b1;
    fill_check(1'b1, 16'h0046, 0);

    // reset during DRAIN after 5 words
    d_addr = 16'h2008;
    d_miss = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      check("part_op", 32'(d_cacheop),
            (c > lat) ? 32'd1 : 32'd0);
    end
    check("part_faddr", 32'(fill_addr), 32'h2008);
    rst_n = 1'b0;
    #1 reset_check();
    @(negedge clk);
    rst_n = 1'b1;
    fill_check(1'b1, 16'h2008, 0);

    // single-cycle memory latency
    lat    = 1;
    d_addr = 16'h0ABC;
    d_miss = 1'b1;
    fill_check(1'b1, 16'h0ABC, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
